// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Program-counter owner; fetches words over req/valid and issues
//            one EXEC cycle per instruction, halting on a self-jump.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                   BUS_WIDTH = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    output logic [BUS_WIDTH-1:0] o_mem_addr,
    output logic                 o_mem_req,
    input  logic [BUS_WIDTH-1:0] i_mem_data,
    input  logic                 i_mem_valid,
    output logic [BUS_WIDTH-1:0] o_l,
    output logic                 o_exec,
    input  logic                 i_j,
    input  logic [BUS_WIDTH-1:0] i_A,
    output logic [BUS_WIDTH-1:0] o_pc,
    output logic                 o_halted,
    output logic [BUS_WIDTH-1:0] o_icount
);

    localparam logic [BUS_WIDTH-1:0] c_one = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BUS_WIDTH-1:0] r_pc;
    logic [BUS_WIDTH-1:0] r_l;
    logic [BUS_WIDTH-1:0] r_icount;
    logic [BUS_WIDTH-1:0] w_pc_next;
    logic                 w_self_jump;

    // A self-jump targets the current PC, so taking i_A leaves the PC unchanged.
    assign w_self_jump = i_j && (i_A == r_pc);
    assign w_pc_next   = i_j ? i_A : (r_pc + c_one);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_l      <= '0;
            r_icount <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && i_mem_valid) begin
                r_l <= i_mem_data;
            end
            if (r_state == S_EXEC) begin
                r_pc     <= w_pc_next;
                r_icount <= r_icount + c_one;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_mem_valid) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_self_jump) begin
                    w_state_next = S_HALT;
                end else if (i_run) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Every output is a register or a pure state decode.
    assign o_mem_req  = (r_state == S_FETCH);
    assign o_exec     = (r_state == S_EXEC);
    assign o_halted   = (r_state == S_HALT);
    assign o_mem_addr = r_pc;
    assign o_pc       = r_pc;
    assign o_l        = r_l;
    assign o_icount   = r_icount;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction sequencer that drives the control unit from the fetch side. It owns the program counter and fetches instruction words from an instruction memory over a request/valid handshake. It presents each word on `o_l` for exactly one execute cycle, then samples the control unit's jump flag and jump address to choose the next program counter. It also handles start/stop, detects halt on a self-jump, and counts retired instructions.

## Interface
Parameters:
- `BUS_WIDTH`, 16: instruction, address and counter width.
- `RESET_PC`, 0: program counter value after reset.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_run`  in  1  level; 1 = execute program, 0 = stop after the current instruction.
- `o_mem_addr`  out  BUS_WIDTH  instruction memory address (equals PC).
- `o_mem_req`  out  1  fetch request.
- `i_mem_data`  in  BUS_WIDTH  instruction word; meaningful only when `i_mem_valid`=1.
- `i_mem_valid`  in  1  memory response strobe; qualified by `o_mem_req`.
- `o_l`  out  BUS_WIDTH  current instruction word to the control unit.
- `o_exec`  out  1  1 for exactly one cycle per instruction; the control unit commits state only when it is 1.
- `i_j`  in  1  jump flag from the control unit, sampled in the EXEC cycle.
- `i_A`  in  BUS_WIDTH  jump target (control unit A register), sampled with `i_j`.
- `o_pc`  out  BUS_WIDTH  program counter.
- `o_halted`  out  1  1 while in the HALT state.
- `o_icount`  out  BUS_WIDTH  retired-instruction count.

## Operation
- States: IDLE, FETCH, EXEC, HALT. All outputs are registered or decoded from state only; there is no combinational path from `i_j`/`i_A` to any output.
- Reset (asynchronous, takes effect immediately, including mid-fetch or mid-exec):
  - state=IDLE, `o_pc`=RESET_PC, `o_l`=0, `o_icount`=0.
  - `o_mem_req`=0, `o_exec`=0, `o_halted`=0.
  - `o_mem_addr`=RESET_PC.
- IDLE:
  - `i_run`=1 → FETCH.
  - Otherwise remain in IDLE.
- FETCH:
  - `o_mem_req`=1 and `o_mem_addr`=`o_pc`, both held stable until the response arrives.
  - On an edge with `i_mem_valid`=1: `o_l` ← `i_mem_data`, go to EXEC.
  - `i_mem_valid` is ignored in every state other than FETCH.
  - `i_run` falling during FETCH does not abort the fetch.
- EXEC (one cycle, `o_exec`=1, `o_mem_req`=0):
  - Next PC: if `i_j`=1, `o_pc` ← `i_A`; otherwise `o_pc` ← `o_pc`+1, modulo 2^BUS_WIDTH (0xFFFF+1 wraps to 0x0000).
  - `o_icount` ← `o_icount`+1, wrapping modulo 2^BUS_WIDTH.
  - Next state:
    - `i_j`=1 and `i_A`=`o_pc` (self-jump) → HALT, with `o_pc` unchanged.
    - Otherwise, `i_run`=1 → FETCH.
    - Otherwise → IDLE.
- HALT:
  - `o_halted`=1; no requests issued; `o_pc` and `o_icount` frozen.
  - Left only by reset; `i_run` is ignored.
- `o_l` holds the last fetched word in every state except reset.

## Timing
- Fetch latency: `o_mem_req` rises on the edge entering FETCH.
- Zero-wait memory (`i_mem_valid`=1 in the first FETCH cycle):
  - FETCH lasts 1 cycle.
  - Throughput is one instruction per 2 cycles: FETCH, EXEC, FETCH, …
- Memory with N wait cycles: FETCH lasts N+1 cycles.
- `o_exec` is high in the cycle after the accepting edge. `o_l` is valid for that whole cycle.
- PC updates on the edge that ends EXEC. The next `o_mem_addr` reflects the new PC in the same cycle that `o_mem_req` rises.
- IDLE→FETCH: one cycle after `i_run` is sampled high.
- A stop is seen at the EXEC edge. The instruction in flight always retires before entering IDLE.

## Test plan
- Reset then `i_run`=1, zero-wait memory returning 0x1111, 0x2222, `i_j`=0 → fetch addresses 0,1,2; `o_exec` pulses every 2nd cycle; `o_l`=0x1111 then 0x2222; `o_icount`=2 after the second EXEC.
- Memory inserts 3 wait cycles → `o_mem_req` held 4 cycles with `o_mem_addr` stable; exactly one `o_exec` pulse; `i_mem_valid` pulsed in IDLE and EXEC has no effect.
- `i_j`=1, `i_A`=0x0040 in EXEC at PC 5 → next `o_mem_addr`=0x0040. `RESET_PC`=0xFFFF with `i_j`=0 → next PC 0x0000.
- `i_j`=1, `i_A`=`o_pc`=0x0007 → `o_halted`=1 and `o_pc` stays 0x0007; no further `o_mem_req`, even with `i_run` toggled.
- `i_run` dropped during FETCH → that instruction still gets its EXEC, then IDLE with PC advanced by 1.
- `i_rst_n` pulled low mid-FETCH, between edges → `o_mem_req`=0 and `o_pc`=RESET_PC immediately. After release with `i_run`=1, fetch restarts at RESET_PC.
